// File: rtl/axil_native_bridge.sv
// axil_native_bridge: AXI4-Lite slave that forwards each transaction as one PicoRV32
// native memory request (mem_valid/mem_ready).
// AW, W and AR each have a one-entry buffer. A single native request is in flight at a time.
// Reads and writes that are ready together are granted in round-robin order.
// Optional macro AXIL_NATIVE_DECERR_EN: an address outside the WIN_BASE/WIN_MASK window is
// answered with DECERR and no native request is issued.
module axil_native_bridge #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter logic [31:0] WIN_BASE   = 32'h0000_0000,
   parameter logic [31:0] WIN_MASK   = 32'hF000_0000
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   output logic [1:0]            s_axi_bresp,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  mem_valid,
   output logic                  mem_instr,
   input  logic                  mem_ready,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic [31:0]           mem_rdata
);

   typedef enum logic [2:0] {StIdle, StWrReq, StRdReq, StWrResp, StRdResp} state_e;

   localparam logic       GrantRd    = 1'b0;
   localparam logic       GrantWr    = 1'b1;
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespDecerr = 2'b11;

   state_e                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  aw_full_q, aw_full_d;
   logic                  w_full_q, w_full_d;
   logic                  ar_full_q, ar_full_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
   logic [31:0]           w_data_q, w_data_d;
   logic [3:0]            w_strb_q, w_strb_d;
   logic                  mem_valid_q, mem_valid_d;
   logic [31:0]           mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_wstrb_q, mem_wstrb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [31:0]           rdata_q, rdata_d;

   logic decerr_en;
   logic aw_in_win, ar_in_win;
   logic wr_rdy, rd_rdy, grant_wr, grant_rd;

   // Window decode is always computed; decerr_en (constant) decides whether it takes effect.
`ifdef AXIL_NATIVE_DECERR_EN
   assign decerr_en = 1'b1;
`else
   assign decerr_en = 1'b0;
`endif
   assign aw_in_win = ((32'(aw_addr_q) & WIN_MASK) == WIN_BASE);
   assign ar_in_win = ((32'(ar_addr_q) & WIN_MASK) == WIN_BASE);

   // Round-robin: on contention grant the opposite of the last winner
   assign wr_rdy   = aw_full_q && w_full_q;
   assign rd_rdy   = ar_full_q;
   assign grant_wr = wr_rdy && (!rd_rdy || (last_grant_q == GrantRd));
   assign grant_rd = rd_rdy && !grant_wr;

   // Next-state: buffer capture, grant, native request and AXI response sequencing
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      aw_full_d    = aw_full_q;
      w_full_d     = w_full_q;
      ar_full_d    = ar_full_q;
      aw_addr_d    = aw_addr_q;
      ar_addr_d    = ar_addr_q;
      w_data_d     = w_data_q;
      w_strb_d     = w_strb_q;
      mem_valid_d  = mem_valid_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wstrb_d  = mem_wstrb_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      rvalid_d     = rvalid_q;
      rresp_d      = rresp_q;
      rdata_d      = rdata_q;

      // A buffer is only freed while full, so fire and free never collide
      if (s_axi_awvalid && !aw_full_q) begin
         aw_full_d = 1'b1;
         aw_addr_d = s_axi_awaddr;
      end
      if (s_axi_wvalid && !w_full_q) begin
         w_full_d = 1'b1;
         w_data_d = s_axi_wdata;
         w_strb_d = s_axi_wstrb;
      end
      if (s_axi_arvalid && !ar_full_q) begin
         ar_full_d = 1'b1;
         ar_addr_d = s_axi_araddr;
      end

      unique case (state_q)
         StIdle: begin
            if (grant_wr) begin
               last_grant_d = GrantWr;
               if (decerr_en && !aw_in_win) begin
                  aw_full_d = 1'b0;
                  w_full_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = RespDecerr;
                  state_d   = StWrResp;
               end else begin
                  mem_valid_d = 1'b1;
                  mem_addr_d  = 32'(aw_addr_q);
                  mem_wdata_d = w_data_q;
                  mem_wstrb_d = w_strb_q;
                  state_d     = StWrReq;
               end
            end else if (grant_rd) begin
               last_grant_d = GrantRd;
               if (decerr_en && !ar_in_win) begin
                  ar_full_d = 1'b0;
                  rvalid_d  = 1'b1;
                  rresp_d   = RespDecerr;
                  rdata_d   = 32'hDEAD_BEEF;
                  state_d   = StRdResp;
               end else begin
                  mem_valid_d = 1'b1;
                  mem_addr_d  = 32'(ar_addr_q);
                  mem_wdata_d = 32'h0;
                  mem_wstrb_d = 4'h0;
                  state_d     = StRdReq;
               end
            end
         end
         StWrReq: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               aw_full_d   = 1'b0;
               w_full_d    = 1'b0;
               bvalid_d    = 1'b1;
               bresp_d     = RespOkay;
               state_d     = StWrResp;
            end
         end
         StRdReq: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               ar_full_d   = 1'b0;
               rvalid_d    = 1'b1;
               rresp_d     = RespOkay;
               rdata_d     = mem_rdata;
               state_d     = StRdResp;
            end
         end
         StWrResp: begin
            if (s_axi_bready) begin
               bvalid_d = 1'b0;
               state_d  = StIdle;
            end
         end
         StRdResp: begin
            if (s_axi_rready) begin
               rvalid_d = 1'b0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered outputs; reset abandons any in-flight request or response
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StIdle;
         last_grant_q <= GrantRd;
         aw_full_q    <= 1'b0;
         w_full_q     <= 1'b0;
         ar_full_q    <= 1'b0;
         aw_addr_q    <= '0;
         ar_addr_q    <= '0;
         w_data_q     <= 32'h0;
         w_strb_q     <= 4'h0;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         mem_wstrb_q  <= 4'h0;
         bvalid_q     <= 1'b0;
         bresp_q      <= RespOkay;
         rvalid_q     <= 1'b0;
         rresp_q      <= RespOkay;
         rdata_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         aw_full_q    <= aw_full_d;
         w_full_q     <= w_full_d;
         ar_full_q    <= ar_full_d;
         aw_addr_q    <= aw_addr_d;
         ar_addr_q    <= ar_addr_d;
         w_data_q     <= w_data_d;
         w_strb_q     <= w_strb_d;
         mem_valid_q  <= mem_valid_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wstrb_q  <= mem_wstrb_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         rvalid_q     <= rvalid_d;
         rresp_q      <= rresp_d;
         rdata_q      <= rdata_d;
      end
   end

   assign s_axi_awready = !aw_full_q;
   assign s_axi_wready  = !w_full_q;
   assign s_axi_arready = !ar_full_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign mem_valid     = mem_valid_q;
   assign mem_instr     = 1'b0;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wstrb     = mem_wstrb_q;

endmodule

// File: tb/tb_axil_native_bridge.sv
// Directed testbench for axil_native_bridge with a small native memory model.
// Covers reset values, write/read flows, back-pressure, arbitration, async reset, strobes
// and the AXIL_NATIVE_DECERR_EN window behaviour (either build).
module tb_axil_native_bridge;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        awvalid = 1'b0, awready;
   logic [31:0] awaddr = 32'h0;
   logic        wvalid = 1'b0, wready;
   logic [31:0] wdata = 32'h0;
   logic [3:0]  wstrb = 4'h0;
   logic        bvalid, bready = 1'b0;
   logic [1:0]  bresp;
   logic        arvalid = 1'b0, arready;
   logic [31:0] araddr = 32'h0;
   logic        rvalid, rready = 1'b0;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        mem_valid, mem_instr, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   axil_native_bridge dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_awaddr  (awaddr),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_bresp   (bresp),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_araddr  (araddr),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .mem_valid     (mem_valid),
      .mem_instr     (mem_instr),
      .mem_ready     (mem_ready),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb),
      .mem_rdata     (mem_rdata)
   );

   // Native memory model: mem_wait wait cycles, then one-cycle completion
   logic [31:0] mem_arr [0:255];
   logic        force_en = 1'b0;
   logic [31:0] force_val = 32'h0;
   int unsigned mem_wait = 0;
   int unsigned wait_cnt;
   int unsigned req_cnt = 0;
   logic [31:0] log_addr, log_wdata;
   logic [3:0]  log_wstrb;
   logic        log_is_wr [0:15];

   assign mem_ready = mem_valid && (wait_cnt == mem_wait);
   assign mem_rdata = force_en ? force_val : mem_arr[mem_addr[9:2]];

   always @(posedge clk or negedge resetn) begin
      if (!resetn) wait_cnt <= 0;
      else if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   always @(posedge clk) begin
      if (mem_valid && mem_ready) begin
         req_cnt <= req_cnt + 1;
         log_addr <= mem_addr;
         log_wdata <= mem_wdata;
         log_wstrb <= mem_wstrb;
         log_is_wr[req_cnt[3:0]] <= (mem_wstrb != 4'h0);
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
      bit got = 0;
      @(negedge clk);
      awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s; bready = 1'b0;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bvalid) begin got = 1; break; end
         @(negedge clk);
      end
      vectors++;
      if (!got) begin errors++; $display("FAIL write_timeout: bvalid got 0 expected 1"); end
      resp = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output bit saw_mv);
      bit got = 0;
      saw_mv = 0;
      @(negedge clk);
      arvalid = 1'b1; araddr = a; rready = 1'b0;
      @(negedge clk);
      arvalid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (rvalid) begin got = 1; break; end
         if (mem_valid) saw_mv = 1;
         @(negedge clk);
      end
      vectors++;
      if (!got) begin errors++; $display("FAIL read_timeout: rvalid got 0 expected 1"); end
      d = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({awready, wready, arready} !== 3'b111) begin
         errors++; $display("FAIL reset_readies: got %b expected 111", {awready, wready, arready});
      end
      vectors++;
      if ({bvalid, rvalid, mem_valid, mem_instr} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_valids: got %b expected 0000", {bvalid, rvalid, mem_valid, mem_instr});
      end
      vectors++;
      if ({bresp, rresp, mem_wstrb} !== 8'h00) begin
         errors++; $display("FAIL reset_resp_strb: got %h expected 00", {bresp, rresp, mem_wstrb});
      end
      vectors++;
      if ({mem_addr, mem_wdata} !== 64'h0) begin
         errors++; $display("FAIL reset_payload: got %h expected 0", {mem_addr, mem_wdata});
      end
   endtask

   task automatic test_write_order();
      int unsigned n0 = req_cnt;
      bit got = 0;
      mem_wait = 0; bready = 1'b0;
      @(negedge clk); awvalid = 1'b1; awaddr = 32'h0000_0100;
      @(negedge clk); awvalid = 1'b0;
      vectors++;
      if (awready !== 1'b0) begin
         errors++; $display("FAIL aw_buffer_full: awready got %b expected 0", awready);
      end
      @(negedge clk); wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF;
      @(negedge clk); wvalid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bvalid) begin got = 1; break; end
         @(negedge clk);
      end
      vectors++;
      if (!got || bresp !== 2'b00) begin
         errors++; $display("FAIL wr_bresp: bvalid %b bresp %b expected 1/00", got, bresp);
      end
      vectors++;
      if (req_cnt - n0 !== 1) begin
         errors++; $display("FAIL wr_req_count: got %0d expected 1", req_cnt - n0);
      end
      vectors++;
      if ({log_addr, log_wdata, log_wstrb} !== {32'h100, 32'h1234_5678, 4'hF}) begin
         errors++;
         $display("FAIL wr_native: got %h/%h/%h expected 100/12345678/f",
                  log_addr, log_wdata, log_wstrb);
      end
      vectors++;
      if (mem_arr[8'h40] !== 32'h1234_5678) begin
         errors++; $display("FAIL wr_mem: got %h expected 12345678", mem_arr[8'h40]);
      end
      bready = 1'b1;
      @(negedge clk); bready = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (bvalid !== 1'b0 || req_cnt - n0 !== 1) begin
         errors++; $display("FAIL wr_done: bvalid %b reqs %0d expected 0/1", bvalid, req_cnt - n0);
      end
   endtask

   task automatic test_read_backpressure();
      int mv_cycles = 0;
      bit got = 0;
      mem_wait = 3; force_en = 1'b1; force_val = 32'hCAFE_F00D; rready = 1'b0;
      @(negedge clk); arvalid = 1'b1; araddr = 32'h0000_0100;
      @(negedge clk); arvalid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rvalid) begin got = 1; break; end
         if (mem_valid) begin
            mv_cycles++;
            vectors++;
            if (mem_addr !== 32'h100 || mem_wstrb !== 4'h0) begin
               errors++;
               $display("FAIL rd_req_stable: addr %h strb %h expected 100/0", mem_addr, mem_wstrb);
            end
         end
         @(negedge clk);
      end
      vectors++;
      if (!got || mv_cycles != 4) begin
         errors++; $display("FAIL rd_wait_cycles: rvalid %b cycles %0d expected 1/4", got, mv_cycles);
      end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (rvalid !== 1'b1 || rdata !== 32'hCAFE_F00D || rresp !== 2'b00) begin
            errors++;
            $display("FAIL rd_hold: rvalid %b rdata %h rresp %b expected 1/cafef00d/00",
                     rvalid, rdata, rresp);
         end
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk); rready = 1'b0;
      vectors++;
      if (rvalid !== 1'b0) begin
         errors++; $display("FAIL rd_release: rvalid got %b expected 0", rvalid);
      end
      force_en = 1'b0; mem_wait = 0;
   endtask

   task automatic both_pending(input bit exp_first_wr);
      int unsigned n0 = req_cnt;
      bit got = 0;
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      awvalid = 1'b1; awaddr = 32'h200; wvalid = 1'b1; wdata = 32'h0BAD_0200; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h300;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (req_cnt - n0 == 2) begin got = 1; break; end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      vectors++;
      if (!got || log_is_wr[n0[3:0]] !== exp_first_wr || log_is_wr[(n0 + 1) % 16] !== !exp_first_wr)
      begin
         errors++;
         $display("FAIL arb_order: done %b first_wr %b second_wr %b expected first_wr %b",
                  got, log_is_wr[n0[3:0]], log_is_wr[(n0 + 1) % 16], exp_first_wr);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_arbitration();
      logic [1:0] r;
      do_reset();
      both_pending(1'b1);
      both_pending(1'b1);
      do_write(32'h204, 32'h1, 4'hF, r);
      both_pending(1'b0);
   endtask

   task automatic test_async_reset();
      int unsigned n0;
      logic [1:0] r;
      bit got = 0;
      mem_wait = 10; bready = 1'b0;
      @(negedge clk);
      awvalid = 1'b1; awaddr = 32'h80; wvalid = 1'b1; wdata = 32'hDEAD_DEAD; wstrb = 4'hF;
      @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (mem_valid) begin got = 1; break; end
         @(negedge clk);
      end
      vectors++;
      if (!got) begin errors++; $display("FAIL rst_pre_req: mem_valid got 0 expected 1"); end
      n0 = req_cnt;
      #2 resetn = 1'b0;
      #1;
      vectors++;
      if ({mem_valid, bvalid, rvalid} !== 3'b000) begin
         errors++;
         $display("FAIL rst_async_valids: got %b expected 000", {mem_valid, bvalid, rvalid});
      end
      vectors++;
      if ({awready, wready, arready} !== 3'b111) begin
         errors++; $display("FAIL rst_async_readies: got %b expected 111", {awready, wready, arready});
      end
      @(negedge clk);
      resetn = 1'b1; mem_wait = 0;
      do_write(32'h80, 32'h55AA_55AA, 4'hF, r);
      vectors++;
      if (r !== 2'b00 || mem_arr[8'h20] !== 32'h55AA_55AA || req_cnt - n0 !== 1) begin
         errors++;
         $display("FAIL rst_fresh_write: resp %b mem %h reqs %0d expected 00/55aa55aa/1",
                  r, mem_arr[8'h20], req_cnt - n0);
      end
   endtask

   task automatic test_partial_strobe();
      logic [1:0] r;
      do_write(32'h40, 32'h1122_3344, 4'hF, r);
      do_write(32'h40, 32'hAABB_CCDD, 4'b0010, r);
      vectors++;
      if (r !== 2'b00 || log_wstrb !== 4'b0010) begin
         errors++; $display("FAIL strb_pass: resp %b wstrb %b expected 00/0010", r, log_wstrb);
      end
      vectors++;
      if (mem_arr[8'h10] !== 32'h1122_CC44) begin
         errors++; $display("FAIL strb_mem: got %h expected 1122cc44", mem_arr[8'h10]);
      end
   endtask

   task automatic test_decerr();
      logic [31:0] d;
      logic [1:0]  r;
      bit          mv;
      int unsigned n0 = req_cnt;
      force_en = 1'b1; force_val = 32'h0BAD_C0DE;
      do_read(32'h2000_0000, d, r, mv);
`ifdef AXIL_NATIVE_DECERR_EN
      vectors++;
      if (mv || req_cnt != n0 || r !== 2'b11 || d !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL decerr_read: mv %b reqs %0d resp %b data %h expected 0/0/11/deadbeef",
                  mv, req_cnt - n0, r, d);
      end
      do_write(32'h3000_0000, 32'h1, 4'hF, r);
      vectors++;
      if (req_cnt != n0 || r !== 2'b11) begin
         errors++; $display("FAIL decerr_write: reqs %0d resp %b expected 0/11", req_cnt - n0, r);
      end
`else
      vectors++;
      if (!mv || req_cnt - n0 != 1 || r !== 2'b00 || d !== 32'h0BAD_C0DE ||
          log_addr !== 32'h2000_0000) begin
         errors++;
         $display("FAIL fwd_read: mv %b reqs %0d resp %b data %h addr %h expected 1/1/00/0badc0de/20000000",
                  mv, req_cnt - n0, r, d, log_addr);
      end
`endif
      force_en = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      test_reset();
      test_write_order();
      test_read_backpressure();
      test_arbitration();
      test_async_reset();
      test_partial_strobe();
      test_decerr();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/axil_native_bridge.md
Name: axil_native_bridge

Overview:
- AXI4-Lite slave (responder) that converts AXI-Lite read/write transactions into PicoRV32 native memory requests (initiator side: mem_valid/mem_ready).
- Lets an emulation-side AXI-Lite master (debug/loader, DMA) reach native-interface memories and peripherals in the emu uncore.
- Handles one outstanding native request at a time, with round-robin read/write arbitration.

Parameters:
- ADDR_WIDTH, 32, AXI and native address width; native mem_addr is zero-extended to 32 bits.
- WIN_BASE, 32'h0000_0000, decode window base (used only with AXIL_NATIVE_DECERR_EN).
- WIN_MASK, 32'hF000_0000, in-window when (addr & WIN_MASK) == WIN_BASE (used only with the macro).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_axi_awvalid/awready  in/out  1/1  AW handshake
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_wvalid/wready  in/out  1/1  W handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_bvalid/bready  out/in  1/1  B handshake
- s_axi_bresp  out  2  write response
- s_axi_arvalid/arready  in/out  1/1  AR handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_rvalid/rready  out/in  1/1  R handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- mem_valid  out  1  native request valid
- mem_instr  out  1  tied to 0
- mem_ready  in  1  native completion
- mem_addr  out  32  request address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  strobes; 0 means read
- mem_rdata  in  32  read data, sampled when mem_valid && mem_ready

Behaviour:
- Reset (asynchronous, immediate): all buffers are empty; state is IDLE; awready=wready=arready=1; bvalid=rvalid=mem_valid=0; bresp=rresp=0; mem_addr/wdata/wstrb=0; last_grant=READ.
- Reset mid-transaction drops mem_valid and any pending B/R without completion.
- Input buffers are one entry each for AW, W and AR:
  - xready = !x_full.
  - x_full is set on the x fire; it is cleared when the native request consuming it completes (mem_valid && mem_ready).
  - AW and W are accepted independently and in either order.
- FSM states are IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP.
- IDLE:
  - wr_ready = aw_full && w_full; rd_ready = ar_full.
  - If both are ready, grant the opposite of last_grant. Otherwise grant whichever is ready.
  - On the next edge: load mem_addr, mem_wdata, mem_wstrb (reads load wstrb=0, wdata=0), set mem_valid=1, update last_grant, and go to WR_REQ or RD_REQ.
- WR_REQ/RD_REQ:
  - mem_valid and the payload are held stable until mem_ready.
  - On mem_ready the edge clears mem_valid and frees the buffer(s).
  - For a read, capture mem_rdata into rdata.
  - Set bvalid (WR_RESP) or rvalid (RD_RESP), with resp=OKAY (2'b00).
- WR_RESP/RD_RESP:
  - bvalid/rvalid and the data are held until bready/rready.
  - The handshake edge clears valid and returns to IDLE.
  - A new request issues no earlier than the cycle after.
- Latency:
  - AW+W fire at edge E gives mem_valid high after E+1.
  - mem_ready at edge M gives bvalid after M.
  - With zero-wait memory and bready=1, a write completes in 4 cycles. Reads are the same.
- New AW/W/AR may be accepted while a native request or response is pending, since the buffers free at mem_ready. At most one native request and one response are in flight.
- Simultaneous events:
  - A same-cycle x fire and buffer-free cannot occur, because x_full already blocks xready.
  - mem_ready while in IDLE or a RESP state is ignored.
- No byte-lane manipulation; wstrb passes through unchanged. awprot and arprot are not used.

Optional Feature:
- Macro: AXIL_NATIVE_DECERR_EN.
- Enabled: at grant, an address with (addr & WIN_MASK) != WIN_BASE skips the REQ state.
  - The buffers are freed on the grant edge; state goes directly to WR_RESP/RD_RESP with resp=DECERR (2'b11).
  - rdata=32'hDEAD_BEEF; mem_valid is never asserted.
- Disabled: every address is forwarded; resp is always OKAY; WIN_BASE and WIN_MASK are unused.

Test Plan:
- Write ordering: AW 0x0000_0100 two cycles before W 0x1234_5678/strb 4'hF, with mem_ready=1 when mem_valid.
  - Exactly one native request: addr 0x100, wdata 0x12345678, wstrb 4'hF.
  - bvalid=1 with bresp=0; the memory model holds the value.
- Read with back-pressure: AR 0x0000_0100; memory returns 0xCAFE_F00D after 3 wait cycles; rready held low 5 cycles.
  - mem_valid and mem_addr stay stable for all 4 cycles.
  - rvalid and rdata=0xCAFEF00D stay stable until rready.
- Arbitration: a write (0x200) and a read (0x300) pending in the same cycle after reset.
  - Write issues first (last_grant reset=READ), then the read.
  - On repeat with both pending, the order alternates again.
- Async reset: assert resetn=0 mid-WR_REQ, with no clock edge.
  - mem_valid, bvalid and rvalid drop immediately; all readies are 1.
  - After release, a fresh write completes normally.
- Partial strobe: W 0xAABBCCDD with strb 4'b0010 to 0x40.
  - mem_wstrb=4'b0010; only byte 1 changes (0xCC).
- DECERR (macro on, defaults): read 0x2000_0000.
  - mem_valid never rises; rresp=2'b11 and rdata=0xDEADBEEF.
  - Macro off: the request is forwarded with OKAY.
